// File: rtl/cam_fill_ctrl.sv
// rtl/cam_fill_ctrl.sv - lookup/fill controller between a requester, a tag CAM and backing memory
// Optional statistics counters: define CAM_FILL_CTRL_STATS_EN
module cam_fill_ctrl #(
   parameter int WORDS     = 8,
   parameter int BITS      = 8,
   parameter int TAG_SZ    = 8,
   parameter int ADDR_LEFT = $clog2(WORDS) - 1,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef CAM_FILL_CTRL_STATS_EN
   output logic [CNT_W-1:0]     hit_cnt,
   output logic [CNT_W-1:0]     miss_cnt,
   output logic [CNT_W-1:0]     evict_cnt,
`endif
   input  logic                 req_valid,
   input  logic [TAG_SZ-1:0]    req_tag,
   output logic                 req_ready,
   output logic                 resp_valid,
   output logic [BITS-1:0]      resp_data,
   output logic                 resp_hit,
   input  logic                 resp_ready,
   input  logic                 flush,
   output logic                 busy,
   output logic [TAG_SZ-1:0]    cam_check_tag,
   output logic                 cam_read,
   output logic                 cam_write_,
   output logic [ADDR_LEFT:0]   cam_w_addr,
   output logic [BITS-1:0]      cam_wdata,
   output logic [TAG_SZ-1:0]    cam_new_tag,
   output logic                 cam_new_valid,
   input  logic [BITS-1:0]      cam_data,
   input  logic                 cam_found,
   input  logic                 cam_full,
   output logic                 mem_req,
   output logic [TAG_SZ-1:0]    mem_tag,
   input  logic                 mem_ack,
   input  logic [BITS-1:0]      mem_rdata
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOOKUP   = 3'd1,
      MISS_REQ = 3'd2,
      FILL     = 3'd3,
      RESP     = 3'd4,
      FLUSH    = 3'd5
   } state_t;

   localparam logic [ADDR_LEFT:0] ONE_IDX  = 1;
   localparam logic [ADDR_LEFT:0] LAST_IDX = (ADDR_LEFT + 1)'(WORDS - 1);

   state_t              state, state_nxt;
   logic [TAG_SZ-1:0]   tag_q;
   logic [BITS-1:0]     data_q;
   logic                hit_q;
   logic [ADDR_LEFT:0]  vptr;
   logic [ADDR_LEFT:0]  fidx;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and all state-decoded outputs
   always_comb begin
      state_nxt     = state;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      resp_data     = '0;
      resp_hit      = 1'b0;
      busy          = 1'b1;
      cam_check_tag = '0;
      cam_read      = 1'b0;
      cam_write_    = 1'b1;
      cam_w_addr    = '0;
      cam_wdata     = '0;
      cam_new_tag   = '0;
      cam_new_valid = 1'b0;
      mem_req       = 1'b0;
      mem_tag       = '0;
      case (state)
         IDLE: begin
            busy      = 1'b0;
            req_ready = ~flush;
            if (flush)          state_nxt = FLUSH;
            else if (req_valid) state_nxt = LOOKUP;
         end
         LOOKUP: begin
            cam_check_tag = tag_q;
            cam_read      = 1'b1;
            state_nxt     = cam_found ? RESP : MISS_REQ;
         end
         MISS_REQ: begin
            mem_req = 1'b1;
            mem_tag = tag_q;
            if (mem_ack) state_nxt = FILL;
         end
         FILL: begin
            cam_write_    = 1'b0;
            cam_w_addr    = vptr;
            cam_new_tag   = tag_q;
            cam_wdata     = data_q;
            cam_new_valid = 1'b1;
            state_nxt     = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_data  = data_q;
            resp_hit   = hit_q;
            if (resp_ready) state_nxt = IDLE;
         end
         FLUSH: begin
            cam_write_ = 1'b0;
            cam_w_addr = fidx;
            if (fidx == LAST_IDX) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request tag, response data/hit, victim pointer and flush index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_q  <= '0;
         data_q <= '0;
         hit_q  <= 1'b0;
         vptr   <= '0;
         fidx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               fidx <= '0;
               if (!flush && req_valid) tag_q <= req_tag;
            end
            LOOKUP: begin
               if (cam_found) begin
                  data_q <= cam_data;
                  hit_q  <= 1'b1;
               end
            end
            MISS_REQ: begin
               if (mem_ack) data_q <= mem_rdata;
            end
            FILL: begin
               hit_q <= 1'b0;
               vptr  <= vptr + ONE_IDX;
            end
            FLUSH: begin
               fidx <= fidx + ONE_IDX;
               if (fidx == LAST_IDX) vptr <= '0;
            end
            default: ;
         endcase
      end
   end

`ifdef CAM_FILL_CTRL_STATS_EN
   localparam logic [CNT_W-1:0] ONE_CNT = 1;

   // Saturating hit/miss/eviction counters, cleared at the start of a flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt   <= '0;
         miss_cnt  <= '0;
         evict_cnt <= '0;
      end else if (state == FLUSH && fidx == '0) begin
         hit_cnt   <= '0;
         miss_cnt  <= '0;
         evict_cnt <= '0;
      end else begin
         if (state == LOOKUP && cam_found && hit_cnt != '1)   hit_cnt  <= hit_cnt + ONE_CNT;
         if (state == LOOKUP && !cam_found && miss_cnt != '1) miss_cnt <= miss_cnt + ONE_CNT;
         if (state == FILL && cam_full && evict_cnt != '1)    evict_cnt <= evict_cnt + ONE_CNT;
      end
   end
`else
   // cam_full and CNT_W only matter to the statistics counters
   logic [CNT_W:0] unused_stats;
   assign unused_stats = {cam_full, {CNT_W{1'b0}}};
`endif

endmodule

// File: tb/tb_cam_fill_ctrl.sv
// tb/tb_cam_fill_ctrl.sv - randomized self-checking bench for cam_fill_ctrl
module tb_cam_fill_ctrl;

   localparam int WORDS = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid, req_ready, resp_valid, resp_hit, resp_ready, flush, busy;
   logic [7:0] req_tag, resp_data;
   logic [7:0] cam_check_tag, cam_wdata, cam_new_tag, cam_data;
   logic [2:0] cam_w_addr;
   logic       cam_read, cam_write_, cam_new_valid, cam_found, cam_full;
   logic       mem_req, mem_ack;
   logic [7:0] mem_tag, mem_rdata;

   cam_fill_ctrl #(.WORDS(WORDS), .BITS(8), .TAG_SZ(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
      .resp_ready(resp_ready), .flush(flush), .busy(busy),
      .cam_check_tag(cam_check_tag), .cam_read(cam_read), .cam_write_(cam_write_),
      .cam_w_addr(cam_w_addr), .cam_wdata(cam_wdata), .cam_new_tag(cam_new_tag),
      .cam_new_valid(cam_new_valid), .cam_data(cam_data), .cam_found(cam_found),
      .cam_full(cam_full), .mem_req(mem_req), .mem_tag(mem_tag),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // CAM environment: stores whatever the controller writes
   logic [7:0]       c_tag [WORDS];
   logic [7:0]       c_dat [WORDS];
   logic [WORDS-1:0] c_val;

   always @(posedge clk or posedge rst) begin
      if (rst) c_val <= '0;
      else if (!cam_write_) begin
         c_val[cam_w_addr] <= cam_new_valid;
         c_tag[cam_w_addr] <= cam_new_tag;
         c_dat[cam_w_addr] <= cam_wdata;
      end
   end

   always_comb begin
      cam_found = 1'b0;
      cam_data  = '0;
      for (int i = 0; i < WORDS; i++)
         if (cam_read && c_val[i] && c_tag[i] == cam_check_tag) begin
            cam_found = 1'b1;
            cam_data  = c_dat[i];
         end
   end
   assign cam_full = &c_val;

   // Reference model: FIFO-replaced list of resident tags
   logic [7:0] m_tag [WORDS];
   bit         m_val [WORDS];
   int         m_ptr;

   function automatic bit m_hit(input logic [7:0] t);
      for (int i = 0; i < WORDS; i++) if (m_val[i] && m_tag[i] == t) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < WORDS; i++) if (m_val[i]) n++;
      return n;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < WORDS; i++) m_val[i] = 1'b0;
      m_ptr = 0;
   endtask

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = 0; req_tag = 0; resp_ready = 0; flush = 0;
      mem_ack = 0; mem_rdata = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_wr_n", cam_write_, 1);
      chk("rst_outs", {resp_valid, resp_hit, resp_data, cam_read, mem_req, mem_tag,
                       cam_check_tag, cam_w_addr, cam_wdata, cam_new_tag, cam_new_valid}, 0);
      m_clear();
   endtask

   task automatic do_req(input logic [7:0] t, input int hold, input int mdly);
      bit         exp_hit;
      logic [7:0] exp_dat;
      exp_hit = m_hit(t);
      exp_dat = t ^ 8'hB4;
      @(negedge clk);
      req_valid = 1'b1; req_tag = t;
      #1 chk("req_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0; req_tag = 8'($urandom);
      chk("lk_read", cam_read, 1);
      chk("lk_tag", cam_check_tag, t);
      chk("lk_wr_n", cam_write_, 1);
      chk("lk_busy", busy, 1);
      if (!exp_hit) begin
         @(negedge clk);
         chk("miss_mem_req", mem_req, 1);
         chk("miss_mem_tag", mem_tag, t);
         chk("miss_resp_valid", resp_valid, 0);
         repeat (mdly) begin
            @(negedge clk);
            chk("miss_mem_hold", {mem_req, mem_tag}, {1'b1, t});
         end
         mem_ack = 1'b1; mem_rdata = exp_dat;
         @(negedge clk);
         mem_ack = 1'b0; mem_rdata = 8'($urandom);
         chk("fill_wr_n", cam_write_, 0);
         chk("fill_read", cam_read, 0);
         chk("fill_addr", cam_w_addr, m_ptr);
         chk("fill_tag", cam_new_tag, t);
         chk("fill_wdata", cam_wdata, exp_dat);
         chk("fill_valid", cam_new_valid, 1);
         chk("fill_mem_req", mem_req, 0);
         chk("fill_full", cam_full, m_count() == WORDS);
         m_tag[m_ptr] = t;
         m_val[m_ptr] = 1'b1;
         m_ptr = (m_ptr + 1) % WORDS;
      end
      @(negedge clk);
      chk("resp_valid", resp_valid, 1);
      chk("resp_data", resp_data, exp_dat);
      chk("resp_hit", resp_hit, exp_hit);
      chk("resp_mem_req", mem_req, 0);
      repeat (hold) begin
         @(negedge clk);
         chk("hold_resp", {resp_valid, resp_hit, resp_data}, {1'b1, exp_hit, exp_dat});
         chk("hold_req_ready", req_ready, 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_req_ready", req_ready, 1);
      chk("idle_resp_valid", resp_valid, 0);
   endtask

   task automatic do_flush(input bit with_req);
      @(negedge clk);
      flush = 1'b1; req_valid = with_req; req_tag = 8'h77;
      #1 chk("flush_req_ready", req_ready, 0);
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0;
      for (int i = 0; i < WORDS; i++) begin
         chk("flush_wr_n", cam_write_, 0);
         chk("flush_addr", cam_w_addr, i);
         chk("flush_zero", {cam_new_valid, cam_new_tag, cam_wdata, cam_read}, 0);
         chk("flush_busy", busy, 1);
         flush = (i == 3);
         @(negedge clk);
         flush = 1'b0;
      end
      chk("flush_done_busy", busy, 0);
      chk("flush_done_wr_n", cam_write_, 1);
      m_clear();
   endtask

   initial begin
      do_reset();

      // first miss fills slot 0, then the same tag hits, then a held response
      do_req(8'h11, 0, 1);
      do_req(8'h11, 0, 0);
      do_req(8'h11, 5, 0);

      // nine distinct fills wrap the victim pointer; the oldest tag is evicted
      do_reset();
      for (int i = 0; i < 9; i++) do_req(8'h20 + 8'(i), 0, i % 3);
      chk("evicted_0x20", m_hit(8'h20), 0);
      do_req(8'h20, 0, 0);

      // flush beats a simultaneous request; next fill restarts at slot 0
      do_flush(1'b1);
      do_req(8'h21, 0, 2);
      do_req(8'h21, 1, 0);

      // reset while waiting on backing memory
      @(negedge clk);
      req_valid = 1'b1; req_tag = 8'h55;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("mid_mem_req", mem_req, 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_mem_req", mem_req, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_resp_valid", resp_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("mid_rst_req_ready", req_ready, 1);
      m_clear();

      // randomized mix of lookups and flushes over a small tag space
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 9) == 0) do_flush(1'($urandom_range(0, 1)));
         else do_req(8'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
